// File: rtl/lzd_arbiter.sv
// lzd_arbiter: round-robin arbiter between two requesters feeding a
// two-cycle leading-zero count and normalise unit with a ready/valid result port.
module lzd_arbiter #(
    parameter int W  = 48,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_data,
    output logic          req1_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_id,
    output logic [CW-1:0] res_lz,
    output logic [W-1:0]  res_norm,
    output logic          res_zero
);
    typedef enum logic [1:0] {IDLE, COUNT, SHIFT, OUT} state_t;
    state_t state_q, state_d;
    logic [W-1:0] op_q, op_d, res_norm_q, res_norm_d;
    logic [CW-1:0] cnt_q, cnt_d, res_lz_q, res_lz_d, lz;
    logic id_q, id_d, last_q, last_d, res_valid_q, res_valid_d;
    logic res_id_q, res_id_d, res_zero_q, res_zero_d;
    logic idle, grant, acc;

    // Ready is gated by rst_n so it stays low while reset is held.
    assign idle       = rst_n && state_q == IDLE;
    assign grant      = (req0_valid && req1_valid) ? !last_q : req1_valid;
    assign req0_ready = idle && !grant;
    assign req1_ready = idle && grant;
    assign acc        = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_lz    = res_lz_q;
    assign res_norm  = res_norm_q;
    assign res_zero  = res_zero_q;

    // Highest set bit wins; an all-zero operand keeps the default of W.
    always_comb begin
        lz = CW'(W);
        for (int i = 0; i < W; i++)
            if (op_q[i]) lz = CW'(W - 1 - i);
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_lz_d    = res_lz_q;
        res_norm_d  = res_norm_q;
        res_zero_d  = res_zero_q;
        case (state_q)
            IDLE: if (acc) begin
                op_d    = grant ? req1_data : req0_data;
                id_d    = grant;
                last_d  = grant;
                state_d = COUNT;
            end
            COUNT: begin
                cnt_d   = lz;
                state_d = SHIFT;
            end
            SHIFT: begin
                res_norm_d  = op_q << cnt_q;
                res_lz_d    = cnt_q;
                res_zero_d  = ~|op_q;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = OUT;
            end
            default: if (res_ready) begin
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_lz_q    <= '0;
            res_norm_q  <= '0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_lz_q    <= res_lz_d;
            res_norm_q  <= res_norm_d;
            res_zero_q  <= res_zero_d;
        end
    end
endmodule

// File: tb/tb_lzd_arbiter.sv
// tb_lzd_arbiter: randomized and directed checks of lzd_arbiter against a
// behavioural leading-zero model and the arbitration/latency rules.
module tb_lzd_arbiter;
    localparam int W  = 48;
    localparam int CW = 6;

    logic clk, rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_data, req1_data, res_norm;
    logic res_valid, res_ready, res_id, res_zero;
    logic [CW-1:0] res_lz;
    int checks = 0, errors = 0, cyc = 0;

    lzd_arbiter #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_lz(res_lz), .res_norm(res_norm), .res_zero(res_zero)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic int model_lz(input logic [W-1:0] v);
        int n = 0;
        while (n < W && v[W-1-n] == 1'b0) n++;
        return n;
    endfunction

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        return v >> $urandom_range(0, W);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic do_txn(input bit who, input logic [W-1:0] d, input int elz,
                          input logic [W-1:0] enorm, input string nm);
        @(negedge clk);
        res_ready = 1;
        if (who) begin req1_valid = 1; req1_data = d; end
        else begin req0_valid = 1; req0_data = d; end
        #1;
        checks++;
        if ((who ? req1_ready : req0_ready) !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got r0=%b r1=%b want requester %0d", nm, req0_ready, req1_ready, who);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        req0_data = rnd_data(); req1_data = rnd_data();
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early_e1 got res_valid=%b want 0", nm, res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early_e2 got res_valid=%b want 0", nm, res_valid);
        end
        @(negedge clk);
        checks++;
        if ({res_valid, res_id, res_lz, res_norm, res_zero} !== {1'b1, who, CW'(elz), enorm, d == '0}) begin
            errors++;
            $display("FAIL %s_result got v=%b id=%b lz=%0d norm=%h z=%b want v=1 id=%b lz=%0d norm=%h z=%b",
                     nm, res_valid, res_id, res_lz, res_norm, res_zero, who, elz, enorm, d == '0);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || req0_ready !== 1'b1) begin
            errors++; $display("FAIL %s_done got res_valid=%b r0=%b want 0 1", nm, res_valid, req0_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; res_ready = 0;
        req0_valid = 1; req1_valid = 1;
        req0_data = rnd_data(); req1_data = rnd_data();
        repeat (2) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, res_valid, res_id, res_lz, res_norm, res_zero} !== '0) begin
            errors++;
            $display("FAIL reset_state got r0=%b r1=%b v=%b id=%b lz=%0d norm=%h z=%b want all 0",
                     req0_ready, req1_ready, res_valid, res_id, res_lz, res_norm, res_zero);
        end
        rst_n = 1; req0_valid = 0; req1_valid = 0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_idle got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_vectors();
        do_txn(0, 48'h0000_FFFF_5456, 16, 48'hFFFF_5456_0000, "vec_lz16");
        do_txn(1, 48'h0000_0000_0001, 47, 48'h8000_0000_0000, "vec_lz47");
        do_txn(1, 48'h8000_0000_0000, 0, 48'h8000_0000_0000, "vec_lz0");
        do_txn(0, 48'h0, 48, 48'h0, "vec_zero");
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        int n;
        for (int k = 0; k < 20; k++) begin
            d = rnd_data();
            n = model_lz(d);
            do_txn(1'($urandom_range(0, 1)), d, n, d << n, "rand");
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] ed;
        int t, last_cyc, n;
        bit eg;
        apply_reset();
        @(negedge clk);
        res_ready = 1;
        req0_valid = 1; req1_valid = 1;
        req0_data = rnd_data(); req1_data = rnd_data();
        #1;
        last_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            t = 0;
            while (!(req0_ready || req1_ready) && t < 20) begin
                @(negedge clk); #1; t++;
            end
            checks++;
            if (t == 20) begin
                errors++; $display("FAIL rr_wait got no ready want ready within 20 cycles");
                req0_valid = 0; req1_valid = 0;
                return;
            end
            eg = k[0];
            checks++;
            if (req1_ready !== eg || req0_ready !== !eg) begin
                errors++; $display("FAIL rr_grant%0d got r0=%b r1=%b want grant %0d", k, req0_ready, req1_ready, eg);
            end
            if (k > 0) begin
                checks++;
                if (cyc - last_cyc != 4) begin
                    errors++; $display("FAIL rr_spacing%0d got %0d cycles want 4", k, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            ed = eg ? req1_data : req0_data;
            n = model_lz(ed);
            @(posedge clk);
            @(negedge clk);
            req0_data = rnd_data(); req1_data = rnd_data();
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({res_valid, res_id, res_lz, res_norm} !== {1'b1, eg, CW'(n), ed << n}) begin
                errors++;
                $display("FAIL rr_result%0d got v=%b id=%b lz=%0d norm=%h want v=1 id=%b lz=%0d norm=%h",
                         k, res_valid, res_id, res_lz, res_norm, eg, n, ed << n);
            end
            @(negedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        int n;
        d = rnd_data() | 48'h1;
        n = model_lz(d);
        @(negedge clk);
        res_ready = 0;
        req0_valid = 1; req0_data = d;
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1; req0_data = rnd_data(); req1_data = rnd_data();
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_id, res_lz, res_norm, res_zero, req0_ready, req1_ready} !==
                {1'b1, 1'b0, CW'(n), d << n, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b id=%b lz=%0d norm=%h z=%b r0=%b r1=%b want v=1 id=0 lz=%0d norm=%h z=0 r=00",
                         k, res_valid, res_id, res_lz, res_norm, res_zero, req0_ready, req1_ready, n, d << n);
            end
        end
        req0_valid = 0; req1_valid = 0;
        res_ready = 1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || req0_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got res_valid=%b r0=%b want 0 1", res_valid, req0_ready);
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] d;
        d = rnd_data() | 48'h1;
        do_txn(1, d, model_lz(d), d << model_lz(d), "pre_abort");
        @(negedge clk);
        req0_valid = 1; req0_data = rnd_data();
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, res_valid} !== 3'b000) begin
            errors++; $display("FAIL abort_in_reset got r0=%b r1=%b v=%b want 000", req0_ready, req1_ready, res_valid);
        end
        req0_valid = 0; req1_valid = 0;
        #2 rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                errors++; $display("FAIL abort_valid%0d got res_valid=%b want 0", k, res_valid);
            end
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL abort_grant got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_round_robin();
        test_backpressure();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
